shape_cmd_sequencer: RTL and testbench
======================================

Name: shape_cmd_sequencer

Overview:
Upstream command stage for shape_processor. It buffers 32-bit control-SFR write words from a producer on a valid/ready channel, then replays each word to shape_processor as one write. After each write it reads the SFR back and returns the readback word and the error flag on a response channel. Ctrl updates are serialised, and every command gets exactly one status response.

Parameters:
DEPTH, 4, command FIFO depth in entries; power of two, >= 2
CNT_W, 16, width of rejected-command counter

Ports:
clk  input  1  clock; all state on posedge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  producer has a command word
cmd_ready  output  1  FIFO can accept; transfer when cmd_valid && cmd_ready
cmd_data  input  32  ctrl SFR write word (SHAPE/OPERATION fields, KEEP codes allowed), opaque to this block
rsp_valid  output  1  response available
rsp_ready  input  1  consumer accepts response
rsp_data  output  32  read_data captured after the write
rsp_error  output  1  error captured during the write
write  output  1  to shape_processor write
write_data  output  32  to shape_processor write_data
read  output  1  to shape_processor read
read_data  input  32  from shape_processor, valid in the cycle read is high
error  input  1  from shape_processor, valid in the cycle write is high
level  output  $clog2(DEPTH)+1  FIFO occupancy
rejected_count  output  CNT_W  number of commands with error=1, saturating

Behaviour:
- Reset (async, rst_n=0): FIFO empty, level=0, state=IDLE, write=read=0, write_data=0, rsp_valid=0, rsp_data=0, rsp_error=0, rejected_count=0, cmd_ready=1 once released.
- Reset mid-operation drops write/read and rsp_valid immediately. write/read decode from the state register only. In-flight and queued commands are discarded and produce no response.
- FIFO: circular, read/write pointers $clog2(DEPTH)+1 bits, wrap at DEPTH. cmd_ready = !full, from registered level, with no same-cycle bypass. When full, a push is refused even in a cycle that pops.
- Push and pop in the same cycle (not full, not empty) leave level unchanged.
- FSM states: IDLE, WRITE, READ, RESP.
- IDLE: if level>0, pop head into cmd_reg and go to WRITE; else stay.
- WRITE: write=1, write_data=cmd_reg for exactly one cycle. Capture error into rsp_error. Go to READ.
- READ: read=1 for exactly one cycle. Capture read_data into rsp_data. Go to RESP.
- RESP: rsp_valid=1; rsp_data and rsp_error are held stable until rsp_ready.
  - On rsp_valid && rsp_ready with level>0: pop the next command and go directly to WRITE.
  - On rsp_valid && rsp_ready with level=0: go to IDLE.
- write and read are never high together. write_data=cmd_reg in all states; its value matters only while write=1.
- Latency: command accepted into an empty FIFO while in IDLE gives write 2 cycles after the accept edge, read at +3, rsp_valid at +4.
- Throughput: 3 cycles per command with rsp_ready held high.
- rejected_count increments on the edge leaving WRITE when error=1. It saturates at 2^CNT_W-1 and never wraps.
- Ordering: responses are returned strictly in command order, one per accepted command.
- Illegal or KEEP fields are forwarded unchanged. Legality is judged solely by shape_processor via error and the readback.

Test Plan:
- Reset, then push one legal word 0x0000_0102 with error=0 and read_data=0x0000_0102 -> write high exactly 2 cycles after the accept edge with write_data=0x0000_0102, read the next cycle, then rsp_valid=1, rsp_data=0x0000_0102, rsp_error=0; rejected_count=0.
- Push 6 commands back-to-back with DEPTH=4 and rsp_ready=0 -> cmd_ready=0 once level=4; no write occurs while RESP is stalled; after rsp_ready=1 the 6 responses come out in order at 3 cycles each.
- Drive error=1 on 3 of 5 commands -> rsp_error matches per command; rejected_count=3. With CNT_W=2 and 5 errors, count stays at 3.
- Hold rsp_ready=0 for 10 cycles in RESP -> rsp_data and rsp_error are stable, write and read stay 0, and level still grows with pushes.
- Assert rst_n=0 during WRITE with 2 entries queued -> write drops in the same cycle; level=0 and rsp_valid=0; no response appears after release.
- Full FIFO with a simultaneous cmd_valid and pop in RESP -> push refused (cmd_ready was 0); level goes 4 to 3.

Source files
------------

// File: rtl/shape_cmd_sequencer.sv
// Command sequencer in front of shape_processor: queues ctrl SFR write words,
// replays each as a write followed by a readback, and returns one status response per command.
module shape_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [31:0]              cmd_data,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_data,
    output logic                     rsp_error,
    output logic                     write,
    output logic [31:0]              write_data,
    output logic                     read,
    input  logic [31:0]              read_data,
    input  logic                     error,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         rejected_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_e;

    state_e            state_q;
    logic [31:0]       mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q, rd_ptr_q, level_q;
    logic [31:0]       cmd_reg_q, rsp_data_q;
    logic              rsp_error_q;
    logic [CNT_W-1:0]  rej_q;

    logic full, empty, push, pop;

    // Ready comes from the registered level only, so a pop never frees a slot in the same cycle.
    assign full  = (level_q == FULL_LVL);
    assign empty = (level_q == '0);
    assign push  = cmd_valid && !full;
    assign pop   = !empty && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));

    assign cmd_ready      = !full;
    assign level          = level_q;
    assign write          = (state_q == WRITE);
    assign read           = (state_q == READ);
    assign rsp_valid      = (state_q == RESP);
    assign write_data     = cmd_reg_q;
    assign rsp_data       = rsp_data_q;
    assign rsp_error      = rsp_error_q;
    assign rejected_count = rej_q;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= cmd_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            cmd_reg_q   <= '0;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
            rej_q       <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                cmd_reg_q <= mem_q[rd_ptr_q[AW-1:0]];
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase

            case (state_q)
                IDLE: if (pop) state_q <= WRITE;
                WRITE: begin
                    rsp_error_q <= error;
                    if (error && (rej_q != '1)) rej_q <= rej_q + 1'b1;
                    state_q <= READ;
                end
                READ: begin
                    rsp_data_q <= read_data;
                    state_q    <= RESP;
                end
                RESP: if (rsp_ready) state_q <= pop ? WRITE : IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shape_cmd_sequencer.sv
// Randomized bench for shape_cmd_sequencer against a transaction-level scoreboard
// (command queue, expected-response queue, push/write/error tallies).
module tb_shape_cmd_sequencer;

    localparam int DEPTH   = 4;
    localparam int CNT_W   = 3;
    localparam int LW      = $clog2(DEPTH) + 1;
    localparam int REJ_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [31:0]       cmd_data = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [31:0]       rsp_data;
    logic              rsp_error;
    logic              write;
    logic [31:0]       write_data;
    logic              read;
    logic [31:0]       read_data = '0;
    logic              error = 1'b0;
    logic [LW-1:0]     level;
    logic [CNT_W-1:0]  rejected_count;

    always #5 clk = ~clk;

    shape_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_error(rsp_error),
        .write(write), .write_data(write_data), .read(read), .read_data(read_data),
        .error(error), .level(level), .rejected_count(rejected_count)
    );

    typedef struct { logic [31:0] data; logic err; } rsp_t;

    logic [31:0] cmd_q[$];
    rsp_t        exp_rsp[$];
    bit          err_pat[$];
    logic [31:0] rd_pat[$];
    int          wr_cyc[$];
    int pushes, writes, errs, nresp, cyc;
    int push_cyc, last_wr_cyc, last_rd_cyc, last_rsp_cyc;
    bit cur_err;
    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic int exp_lvl();
        return pushes - writes;
    endfunction

    function automatic int exp_rej();
        return (errs > REJ_MAX) ? REJ_MAX : errs;
    endfunction

    task automatic model_clear();
        cmd_q.delete(); exp_rsp.delete(); err_pat.delete(); rd_pat.delete(); wr_cyc.delete();
        pushes = 0; writes = 0; errs = 0; nresp = 0; cur_err = 1'b0;
    endtask

    // One clock: drive inputs, score the edge, then check what the DUT shows afterwards.
    task automatic step(input bit v, input logic [31:0] d, input bit rr, output bit acc);
        bit pw, pr, pv;
        logic [31:0] pd, rd;
        logic pe;
        rsp_t e;
        pw = write; pr = read; pv = rsp_valid; pd = rsp_data; pe = rsp_error;
        cmd_valid = v; cmd_data = d; rsp_ready = rr;
        error = 1'b0; read_data = $urandom;
        if (pw) begin
            cur_err = (err_pat.size() != 0) ? err_pat.pop_front() : 1'($urandom_range(0, 1));
            error = cur_err;
            if (cur_err) errs++;
        end
        if (pr) begin
            rd = (rd_pat.size() != 0) ? rd_pat.pop_front() : $urandom;
            read_data = rd;
            exp_rsp.push_back('{rd, cur_err});
        end
        acc = v && cmd_ready;
        if (acc) begin
            cmd_q.push_back(d); pushes++; push_cyc = cyc;
        end
        if (pv && rr) begin
            nresp++;
            if (exp_rsp.size() == 0) chk("rsp_unexpected", 32'(1), 32'(0));
            else begin
                e = exp_rsp.pop_front();
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_error", 32'(rsp_error), 32'(e.err));
            end
        end
        @(posedge clk); @(negedge clk); cyc++;
        chk("wr_rd_excl", 32'(write & read), 32'(0));
        if (write) begin
            writes++; wr_cyc.push_back(cyc); last_wr_cyc = cyc;
            if (cmd_q.size() == 0) chk("write_unexpected", 32'(1), 32'(0));
            else chk("write_data", write_data, cmd_q.pop_front());
            chk("write_entry", 32'(pw | pr | (pv & !rr)), 32'(0));
        end
        if (read) begin
            last_rd_cyc = cyc;
            chk("read_after_write", 32'(pw), 32'(1));
        end
        if (rsp_valid && !pv) begin
            last_rsp_cyc = cyc;
            chk("rsp_after_read", 32'(pr), 32'(1));
        end
        if (pv && !rr) begin
            chk("rsp_hold", 32'(rsp_valid), 32'(1));
            chk("rsp_data_stable", rsp_data, pd);
            chk("rsp_err_stable", 32'(rsp_error), 32'(pe));
        end
        chk("level", 32'(level), 32'(exp_lvl()));
        chk("cmd_ready", 32'(cmd_ready), 32'(exp_lvl() < DEPTH));
        chk("rejected_count", 32'(rejected_count), 32'(exp_rej()));
    endtask

    task automatic push_n(input int n, input bit rr);
        int got = 0;
        bit acc;
        for (int i = 0; i < 200 && got < n; i++) begin
            step(1'b1, $urandom, rr, acc);
            if (acc) got++;
        end
        chk("push_count", 32'(got), 32'(n));
    endtask

    task automatic wait_resp(input int target);
        bit acc;
        for (int i = 0; i < 300 && nresp < target; i++) step(1'b0, $urandom, 1'b1, acc);
        chk("resp_count", 32'(nresp), 32'(target));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_write", 32'(write), 32'(0));
        chk("rst_read", 32'(read), 32'(0));
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_level", 32'(level), 32'(0));
        chk("rst_write_data", write_data, 32'(0));
        chk("rst_rsp_data", rsp_data, 32'(0));
        chk("rst_rsp_error", 32'(rsp_error), 32'(0));
        chk("rst_rejected", 32'(rejected_count), 32'(0));
        model_clear();
        cmd_valid = 1'b0; rsp_ready = 1'b0; error = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        bit busy;
        cyc = 0;
        model_clear();
        #2;
        do_reset();

        // Single legal command: latency and readback.
        rd_pat.push_back(32'h0000_0102);
        err_pat.push_back(1'b0);
        step(1'b1, 32'h0000_0102, 1'b1, acc);
        chk("t1_accept", 32'(acc), 32'(1));
        wait_resp(1);
        chk("t1_write_lat", 32'(last_wr_cyc - push_cyc), 32'(2));
        chk("t1_read_lat", 32'(last_rd_cyc - push_cyc), 32'(3));
        chk("t1_rsp_lat", 32'(last_rsp_cyc - push_cyc), 32'(4));

        // Fill while the response stalls, then pop from a full FIFO.
        do_reset();
        push_n(5, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, $urandom, 1'b0, acc);
        chk("full_level", 32'(level), 32'(DEPTH));
        chk("full_cmd_ready", 32'(cmd_ready), 32'(0));
        chk("stall_rsp_valid", 32'(rsp_valid), 32'(1));
        wr_cyc.delete();
        step(1'b1, 32'hDEAD_BEEF, 1'b1, acc);
        chk("full_push_refused", 32'(acc), 32'(0));
        chk("full_pop_level", 32'(level), 32'(DEPTH - 1));
        push_n(1, 1'b1);
        wait_resp(6);
        chk("burst_writes", 32'(wr_cyc.size()), 32'(5));
        for (int i = 1; i < wr_cyc.size(); i++)
            chk("throughput", 32'(wr_cyc[i] - wr_cyc[i-1]), 32'(3));

        // Error accounting and saturation.
        do_reset();
        err_pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        push_n(5, 1'b1);
        wait_resp(5);
        chk("rej_3of5", 32'(rejected_count), 32'(3));
        for (int i = 0; i < 6; i++) err_pat.push_back(1'b1);
        push_n(6, 1'b1);
        wait_resp(11);
        chk("rej_saturated", 32'(rejected_count), 32'(REJ_MAX));

        // Reset during WRITE with two entries queued.
        do_reset();
        push_n(4, 1'b0);
        for (int i = 0; i < 50 && !(write && level == LW'(2)); i++) step(1'b0, $urandom, 1'b1, acc);
        chk("pre_reset_write", 32'(write), 32'(1));
        chk("pre_reset_level", 32'(level), 32'(2));
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b0, $urandom, 1'b1, acc);
        chk("no_rsp_after_reset", 32'(nresp), 32'(0));

        // Random traffic.
        do_reset();
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 9) < 6, $urandom, 1'($urandom_range(0, 1)), acc);
        busy = 1'b1;
        for (int i = 0; i < 300 && busy; i++) begin
            step(1'b0, $urandom, 1'b1, acc);
            busy = (cmd_q.size() != 0) || (exp_rsp.size() != 0) || rsp_valid || write || read;
        end
        chk("drain_queues", 32'(cmd_q.size() + exp_rsp.size()), 32'(0));
        chk("drain_level", 32'(level), 32'(0));
        chk("drain_resp_all", 32'(nresp), 32'(pushes));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
